// File: rtl/pdp8_iot_pkg.sv
// Shared PDP-8 IOT definitions: operation codes for console-style keyboard and
// printer devices, plus the device-code map used by the multi-channel controller.
package pdp8_iot_pkg;

  localparam logic [2:0] KCF = 3'd0;
  localparam logic [2:0] KSF = 3'd1;
  localparam logic [2:0] KCC = 3'd2;
  localparam logic [2:0] KRS = 3'd4;
  localparam logic [2:0] KIE = 3'd5;
  localparam logic [2:0] KRB = 3'd6;

  localparam logic [2:0] SPF = 3'd0;
  localparam logic [2:0] TSF = 3'd1;
  localparam logic [2:0] TCF = 3'd2;
  localparam logic [2:0] TPC = 3'd4;
  localparam logic [2:0] SPI = 3'd5;
  localparam logic [2:0] TLS = 3'd6;

  // Channel 0 keeps the classic codes; later channels pair up from alt_base.
  function automatic logic [5:0] dev_code(input int unsigned n, input logic prn,
                                          input logic [5:0] kbd0, input logic [5:0] prn0,
                                          input logic [5:0] alt_base);
    logic [5:0] code;
    if (n == 0) begin
      code = prn ? prn0 : kbd0;
    end else begin
      code = alt_base + 6'(2 * (n - 1)) + {5'd0, prn};
    end
    return code;
  endfunction

endpackage

// File: rtl/kl8_multi_if.sv
// CPU IOT bus plus per-channel RX/TX byte streams of the multi-channel console controller.
interface kl8_multi_if #(parameter int NCH = 4);
  logic             IOT_STB;
  logic [8:0]       IR;
  logic [11:0]      AC;
  logic             IOT_DONE;
  logic             SKIP;
  logic             AC_CLR;
  logic [11:0]      AC_OR;
  logic             IRQ;
  logic [8*NCH-1:0] RX_DATA;
  logic [NCH-1:0]   RX_VALID;
  logic [NCH-1:0]   RX_READY;
  logic [8*NCH-1:0] TX_DATA;
  logic [NCH-1:0]   TX_VALID;
  logic [NCH-1:0]   TX_READY;

  modport master (
    output IOT_STB, IR, AC, RX_DATA, RX_VALID, TX_READY,
    input  IOT_DONE, SKIP, AC_CLR, AC_OR, IRQ, RX_READY, TX_DATA, TX_VALID
  );

  modport slave (
    input  IOT_STB, IR, AC, RX_DATA, RX_VALID, TX_READY,
    output IOT_DONE, SKIP, AC_CLR, AC_OR, IRQ, RX_READY, TX_DATA, TX_VALID
  );
endinterface

// File: rtl/kl8_rx_fifo.sv
// Per-channel keyboard receive FIFO; pushes while full and pops while empty are ignored.
module kl8_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_s, pop_s;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];

  // Storage array; contents are meaningless while the count says empty.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_s) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/kl8_multi.sv
// Multi-channel KL8-style console IOT controller: keyboard RX FIFOs, printer TX
// holding registers, registered IOT responses and a merged interrupt request.
module kl8_multi import pdp8_iot_pkg::*; #(
  parameter int         NCH         = 4,
  parameter int         DEPTH       = 8,
  parameter logic [5:0] KBD0        = 6'o03,
  parameter logic [5:0] PRN0        = 6'o04,
  parameter logic [5:0] ALT_BASE    = 6'o40,
  parameter bit         MARK_PARITY = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET,
  kl8_multi_if.slave   bus
);
  logic [NCH-1:0]   empty_s, full_s, pop_s, hit_k_s, hit_p_s;
  logic [7:0]       head_s     [NCH];
  logic [11:0]      head_val_s [NCH];
  logic [NCH-1:0]   pflag_q, pflag_d, ie_q, ie_d, txv_q, txv_d;
  logic [8*NCH-1:0] txd_q, txd_d;
  logic             done_q, done_d, skip_q, skip_d, clr_q, clr_d;
  logic [11:0]      acor_q, acor_d;
  logic [2:0]       op_s;
  logic             unused_s;

  assign op_s     = bus.IR[2:0];
  assign unused_s = ^bus.AC[11:8];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign hit_k_s[g] = bus.IOT_STB & (bus.IR[8:3] == dev_code(g, 1'b0, KBD0, PRN0, ALT_BASE));
    assign hit_p_s[g] = bus.IOT_STB & (bus.IR[8:3] == dev_code(g, 1'b1, KBD0, PRN0, ALT_BASE));
    assign head_val_s[g] = empty_s[g] ? 12'd0 : {4'd0, head_s[g] | {MARK_PARITY, 7'd0}};

    kl8_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i  (CLK),
      .rst_ni (RESET),
      .push_i (bus.RX_VALID[g]),
      .pop_i  (pop_s[g]),
      .data_i (bus.RX_DATA[8*g +: 8]),
      .full_o (full_s[g]),
      .empty_o(empty_s[g]),
      .head_o (head_s[g])
    );
  end

  // Decode the strobed IOT into per-channel side effects and the CPU response.
  always_comb begin
    done_d  = 1'b0;
    skip_d  = 1'b0;
    clr_d   = 1'b0;
    acor_d  = 12'd0;
    pop_s   = '0;
    ie_d    = ie_q;
    pflag_d = pflag_q;
    txv_d   = txv_q & ~bus.TX_READY;
    txd_d   = txd_q;
    for (int n = 0; n < NCH; n++) begin
      if (hit_k_s[n]) begin
        done_d = 1'b1;
        case (op_s)
          KCF:     pop_s[n] = 1'b1;
          KSF:     skip_d = ~empty_s[n];
          KCC:     begin clr_d = 1'b1; pop_s[n] = 1'b1; end
          KRS:     acor_d = head_val_s[n];
          KIE:     ie_d[n] = bus.AC[0];
          KRB:     begin clr_d = 1'b1; acor_d = head_val_s[n]; pop_s[n] = 1'b1; end
          default: done_d = 1'b1;
        endcase
      end else if (hit_p_s[n]) begin
        done_d = 1'b1;
        case (op_s)
          SPF:     pflag_d[n] = 1'b1;
          TSF:     skip_d = pflag_q[n];
          TCF:     pflag_d[n] = 1'b0;
          TPC:     begin txd_d[8*n +: 8] = bus.AC[7:0]; txv_d[n] = 1'b1; end
          SPI:     skip_d = ie_q[n] & (~empty_s[n] | pflag_q[n]);
          TLS:     begin pflag_d[n] = 1'b0; txd_d[8*n +: 8] = bus.AC[7:0]; txv_d[n] = 1'b1; end
          default: done_d = 1'b1;
        endcase
      end else begin
        pop_s[n] = 1'b0;
      end
      // A completed transmit sets the flag even against a same-cycle clear.
      pflag_d[n] = pflag_d[n] | (txv_q[n] & bus.TX_READY[n]);
    end
  end

  // Response and channel state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      done_q  <= 1'b0;
      skip_q  <= 1'b0;
      clr_q   <= 1'b0;
      acor_q  <= 12'd0;
      pflag_q <= '0;
      ie_q    <= '1;
      txv_q   <= '0;
      txd_q   <= '0;
    end else begin
      done_q  <= done_d;
      skip_q  <= skip_d;
      clr_q   <= clr_d;
      acor_q  <= acor_d;
      pflag_q <= pflag_d;
      ie_q    <= ie_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
    end
  end

  assign bus.IOT_DONE = done_q;
  assign bus.SKIP     = skip_q;
  assign bus.AC_CLR   = clr_q;
  assign bus.AC_OR    = acor_q;
  assign bus.TX_VALID = txv_q;
  assign bus.TX_DATA  = txd_q;
  assign bus.RX_READY = ~full_s;
  assign bus.IRQ      = |(ie_q & (~empty_s | pflag_q));
endmodule

// File: tb/tb_kl8_multi.sv
// Self-checking bench for kl8_multi: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_kl8_multi;
  localparam int NCH   = 4;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  kl8_multi_if #(.NCH(NCH)) bus();

  kl8_multi #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0]  mq [NCH][$];
  bit          m_pflag [NCH];
  bit          m_ie    [NCH];
  bit          m_txv   [NCH];
  logic [7:0]  m_txd   [NCH];

  function automatic logic [5:0] kcode(input int n);
    return (n == 0) ? 6'o03 : 6'(32 + 2 * (n - 1));
  endfunction

  function automatic logic [5:0] pcode(input int n);
    return (n == 0) ? 6'o04 : 6'(33 + 2 * (n - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      mq[n].delete();
      m_pflag[n] = 1'b0;
      m_ie[n]    = 1'b1;
      m_txv[n]   = 1'b0;
      m_txd[n]   = 8'h00;
    end
  endtask

  // One clock: predict from the current inputs, advance the model, then compare.
  task automatic step();
    logic [5:0]       dc;
    logic [2:0]       op;
    logic             e_done, e_skip, e_clr, e_irq;
    logic [11:0]      e_acor;
    logic [NCH-1:0]   e_txv, e_rdy;
    logic [8*NCH-1:0] e_txd;
    logic [7:0]       hv;
    bit               pop, push_ok, set_f, clr_f, load, hs;
    dc = bus.IR[8:3];
    op = bus.IR[2:0];
    e_done = 1'b0; e_skip = 1'b0; e_clr = 1'b0; e_acor = 12'd0;
    for (int n = 0; n < NCH; n++) begin
      pop = 0; set_f = 0; clr_f = 0; load = 0;
      push_ok = bus.RX_VALID[n] && (mq[n].size() < DEPTH);
      hv = (mq[n].size() > 0) ? (mq[n][0] | 8'h80) : 8'h00;
      hs = m_txv[n] && bus.TX_READY[n];
      if (bus.IOT_STB && dc == kcode(n)) begin
        e_done = 1'b1;
        case (op)
          3'd0: pop = 1;
          3'd1: e_skip = (mq[n].size() > 0);
          3'd2: begin e_clr = 1'b1; pop = 1; end
          3'd4: e_acor = {4'h0, hv};
          3'd5: m_ie[n] = bus.AC[0];
          3'd6: begin e_clr = 1'b1; e_acor = {4'h0, hv}; pop = 1; end
          default: ;
        endcase
      end else if (bus.IOT_STB && dc == pcode(n)) begin
        e_done = 1'b1;
        case (op)
          3'd0: set_f = 1;
          3'd1: e_skip = m_pflag[n];
          3'd2: clr_f = 1;
          3'd4: load = 1;
          3'd5: e_skip = m_ie[n] && ((mq[n].size() > 0) || m_pflag[n]);
          3'd6: begin clr_f = 1; load = 1; end
          default: ;
        endcase
      end
      if (pop && mq[n].size() > 0) void'(mq[n].pop_front());
      if (push_ok) mq[n].push_back(bus.RX_DATA[8*n +: 8]);
      m_pflag[n] = hs ? 1'b1 : (clr_f ? 1'b0 : (set_f ? 1'b1 : m_pflag[n]));
      m_txv[n]   = load ? 1'b1 : (hs ? 1'b0 : m_txv[n]);
      if (load) m_txd[n] = bus.AC[7:0];
    end
    e_irq = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      e_txv[n]         = m_txv[n];
      e_txd[8*n +: 8]  = m_txd[n];
      e_rdy[n]         = (mq[n].size() < DEPTH);
      e_irq            = e_irq | (m_ie[n] && ((mq[n].size() > 0) || m_pflag[n]));
    end
    @(posedge clk);
    #1;
    chk("iot_done", bus.IOT_DONE, e_done);
    chk("skip",     bus.SKIP,     e_skip);
    chk("ac_clr",   bus.AC_CLR,   e_clr);
    chk("ac_or",    bus.AC_OR,    e_acor);
    chk("tx_valid", bus.TX_VALID, e_txv);
    chk("tx_data",  bus.TX_DATA,  e_txd);
    chk("rx_ready", bus.RX_READY, e_rdy);
    chk("irq",      bus.IRQ,      e_irq);
  endtask

  task automatic iot(input logic [8:0] ir, input logic [11:0] ac);
    bus.IOT_STB = 1'b1;
    bus.IR      = ir;
    bus.AC      = ac;
    step();
    bus.IOT_STB = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int ch, sel;
    bus.IOT_STB  = 1'b0;
    bus.IR       = 9'd0;
    bus.AC       = 12'd0;
    bus.RX_DATA  = '0;
    bus.RX_VALID = '0;
    bus.TX_READY = '0;
    model_reset();

    #12;
    chk("rst_rx_ready", bus.RX_READY, 4'hF);
    chk("rst_irq",      bus.IRQ,      1'b0);
    chk("rst_done",     bus.IOT_DONE, 1'b0);
    chk("rst_tx_valid", bus.TX_VALID, 4'h0);
    chk("rst_ac_or",    bus.AC_OR,    12'd0);
    chk("rst_tx_data",  bus.TX_DATA,  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    iot(9'o031, 12'd0);
    chk("ksf_empty_done", bus.IOT_DONE, 1'b1);
    chk("ksf_empty_skip", bus.SKIP, 1'b0);

    bus.RX_VALID = 4'b0001;
    bus.RX_DATA[7:0] = 8'h41;
    step();
    bus.RX_VALID = '0;
    chk("irq_rise", bus.IRQ, 1'b1);
    iot(9'o036, 12'd0);
    chk("krb_clr", bus.AC_CLR, 1'b1);
    chk("krb_acor", bus.AC_OR, 12'o0301);
    iot(9'o031, 12'd0);
    chk("ksf_after_krb", bus.SKIP, 1'b0);
    chk("irq_fall", bus.IRQ, 1'b0);

    for (int i = 0; i < 8; i++) begin
      bus.RX_VALID = 4'b0100;
      bus.RX_DATA[23:16] = 8'h30 + 8'(i);
      step();
    end
    chk("ch2_full", bus.RX_READY[2], 1'b0);
    bus.RX_DATA[23:16] = 8'h99;
    iot(9'o420, 12'd0);
    chk("full_push_refused", bus.RX_READY[2], 1'b1);
    bus.RX_DATA[23:16] = 8'h38;
    iot(9'o420, 12'd0);
    chk("push_pop_same", bus.RX_READY[2], 1'b1);
    bus.RX_DATA[23:16] = 8'h39;
    step();
    bus.RX_VALID = '0;
    chk("ch2_full_again", bus.RX_READY[2], 1'b0);
    for (int i = 0; i < 8; i++) begin
      b = 8'h32 + 8'(i);
      iot(9'o426, 12'd0);
      chk("ch2_order", bus.AC_OR, {4'h0, b | 8'h80});
    end

    iot(9'o046, 12'o0115);
    chk("tls_data", bus.TX_DATA[7:0], 8'h4D);
    chk("tls_valid", bus.TX_VALID[0], 1'b1);
    repeat (5) step();
    bus.TX_READY = 4'b0001;
    step();
    bus.TX_READY = '0;
    chk("tx_accepted", bus.TX_VALID[0], 1'b0);
    iot(9'o041, 12'd0);
    chk("tsf_after_tx", bus.SKIP, 1'b1);

    iot(9'o042, 12'd0);
    iot(9'o044, 12'h055);
    bus.TX_READY = 4'b0001;
    iot(9'o042, 12'd0);
    bus.TX_READY = '0;
    iot(9'o041, 12'd0);
    chk("tcf_vs_accept", bus.SKIP, 1'b1);
    iot(9'o035, 12'd0);
    chk("kie_off_irq", bus.IRQ, 1'b0);
    iot(9'o045, 12'd0);
    chk("spi_disabled", bus.SKIP, 1'b0);

    iot(9'o044, 12'h011);
    iot(9'o044, 12'h022);
    chk("tpc_overwrite", bus.TX_DATA[7:0], 8'h22);
    bus.TX_READY = 4'b0001;
    iot(9'o046, 12'h033);
    chk("load_on_accept", bus.TX_VALID[0], 1'b1);
    step();
    bus.TX_READY = '0;

    iot(9'o201, 12'd0);
    chk("unmapped", bus.IOT_DONE, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ch  = $urandom_range(0, NCH - 1);
      sel = $urandom_range(0, 8);
      bus.IOT_STB  = 1'($urandom_range(0, 1));
      bus.IR       = (sel == 8) ? {6'o20, 3'($urandom)} :
                     {((sel % 2) == 1) ? pcode(ch) : kcode(ch), 3'($urandom)};
      bus.AC       = 12'($urandom);
      bus.RX_VALID = 4'($urandom);
      bus.RX_DATA  = 32'($urandom);
      bus.TX_READY = 4'($urandom);
      step();
    end
    bus.IOT_STB  = 1'b0;
    bus.RX_VALID = '0;
    bus.TX_READY = '0;

    bus.RX_VALID = 4'hF;
    step();
    bus.RX_VALID = '0;
    iot(9'o044, 12'h05A);
    chk("pre_reset_tx", bus.TX_VALID[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", bus.TX_VALID, 4'h0);
    chk("mid_rst_rx_ready", bus.RX_READY, 4'hF);
    chk("mid_rst_irq",      bus.IRQ,      1'b0);
    chk("mid_rst_tx_data",  bus.TX_DATA,  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    iot(9'o031, 12'd0);
    chk("post_rst_empty", bus.SKIP, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
